// File: rtl/complex_matrix_addsub_stream_if.sv
// Stream bundle for the complex matrix add/sub engine.
// Master drives operands and output ready; slave returns results and status.
interface complex_matrix_addsub_stream_if #(
   parameter int LANES = 4,
   parameter int WIDTH = 16
);
   localparam int LW = LANES * 2 * WIDTH;

   logic          in_valid_i;
   logic          in_ready_o;
   logic [LW-1:0] a_i;
   logic [LW-1:0] b_i;
   logic [1:0]    op_i;
   logic          flush_i;
   logic [LW-1:0] result_o;
   logic          out_valid_o;
   logic          out_ready_i;
   logic          out_last_o;
   logic          ovf_o;
   logic          frame_ovf_o;
   logic          busy_o;

   modport master (
      output in_valid_i,
      output a_i,
      output b_i,
      output op_i,
      output flush_i,
      output out_ready_i,
      input  in_ready_o,
      input  result_o,
      input  out_valid_o,
      input  out_last_o,
      input  ovf_o,
      input  frame_ovf_o,
      input  busy_o
   );

   modport slave (
      input  in_valid_i,
      input  a_i,
      input  b_i,
      input  op_i,
      input  flush_i,
      input  out_ready_i,
      output in_ready_o,
      output result_o,
      output out_valid_o,
      output out_last_o,
      output ovf_o,
      output frame_ovf_o,
      output busy_o
   );
endinterface

// File: rtl/complex_matrix_addsub_stream.sv
// Two-stage streaming complex add / sub / conj-add over matrix frames,
// with per-beat and per-frame overflow reporting.
module complex_matrix_addsub_stream #(
   parameter int LANES    = 4,
   parameter int WIDTH    = 16,
   parameter int BEATS    = 4,
   parameter int SATURATE = 1
) (
   input logic clk_i,
   input logic rst_i,
   complex_matrix_addsub_stream_if.slave bus
);
   localparam int PARTS = 2 * LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [CW-1:0]    LAST_IDX = CW'(BEATS - 1);
   localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MAX  = {1'b1, {(WIDTH-1){1'b0}}};

   logic [CW-1:0] cnt_q;
   logic [1:0]    op_q;
   logic          fovf_acc_q;

   logic                       s1_valid_q;
   logic                       s1_last_q;
   logic [PARTS-1:0][WIDTH:0]  s1_sum_q;

   logic                       s2_valid_q;
   logic                       s2_last_q;
   logic                       s2_ovf_q;
   logic                       s2_fovf_q;
   logic [PARTS-1:0][WIDTH-1:0] s2_res_q;

   logic                        s2_en;
   logic                        s1_en;
   logic                        s1_move;
   logic                        in_fire;
   logic [1:0]                  op_eff;
   logic [PARTS-1:0][WIDTH:0]   sum_d;
   logic [PARTS-1:0][WIDTH-1:0] res_d;
   logic                        ovf_d;

   assign s2_en   = !s2_valid_q || bus.out_ready_i;
   assign s1_en   = !s1_valid_q || s2_en;
   assign s1_move = s1_valid_q && s2_en;
   assign in_fire = bus.in_valid_i && bus.in_ready_o;

   assign bus.in_ready_o = s1_en && !bus.flush_i;

   // Beat 0 takes op straight from the port; the rest of the frame reuses it.
   always_comb begin
      op_eff = op_q;
      if (cnt_q == '0) begin
         op_eff = (bus.op_i == 2'b11) ? 2'b00 : bus.op_i;
      end
   end

   always_comb begin
      logic [WIDTH:0] ax;
      logic [WIDTH:0] bx;
      logic           sub;
      ax    = '0;
      bx    = '0;
      sub   = 1'b0;
      sum_d = '0;
      for (int p = 0; p < PARTS; p++) begin
         ax  = {bus.a_i[p*WIDTH+WIDTH-1],
                bus.a_i[p*WIDTH +: WIDTH]};
         bx  = {bus.b_i[p*WIDTH+WIDTH-1],
                bus.b_i[p*WIDTH +: WIDTH]};
         sub = (op_eff == 2'b01) ||
               ((op_eff == 2'b10) && ((p % 2) == 1));
         sum_d[p] = sub ? (ax - bx) : (ax + bx);
      end
   end

   // Top two bits disagree exactly when the sum leaves the WIDTH-bit range.
   always_comb begin
      res_d = '0;
      ovf_d = 1'b0;
      for (int p = 0; p < PARTS; p++) begin
         res_d[p] = s1_sum_q[p][WIDTH-1:0];
         if (s1_sum_q[p][WIDTH] != s1_sum_q[p][WIDTH-1]) begin
            ovf_d = 1'b1;
            if (SATURATE != 0) begin
               res_d[p] = s1_sum_q[p][WIDTH] ? NEG_MAX : POS_MAX;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         op_q       <= 2'b00;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_sum_q   <= '0;
      end else if (bus.flush_i) begin
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
      end else begin
         if (s1_en) begin
            s1_valid_q <= in_fire;
         end
         if (in_fire) begin
            s1_sum_q  <= sum_d;
            s1_last_q <= (cnt_q == LAST_IDX);
            cnt_q     <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) begin
               op_q <= op_eff;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_ovf_q   <= 1'b0;
         s2_fovf_q  <= 1'b0;
         s2_res_q   <= '0;
         fovf_acc_q <= 1'b0;
      end else if (bus.flush_i) begin
         s2_valid_q <= 1'b0;
         fovf_acc_q <= 1'b0;
      end else begin
         if (s2_en) begin
            s2_valid_q <= s1_valid_q;
         end
         if (s1_move) begin
            s2_res_q   <= res_d;
            s2_ovf_q   <= ovf_d;
            s2_last_q  <= s1_last_q;
            s2_fovf_q  <= s1_last_q && (fovf_acc_q || ovf_d);
            fovf_acc_q <= !s1_last_q && (fovf_acc_q || ovf_d);
         end
      end
   end

   assign bus.result_o    = s2_res_q;
   assign bus.out_valid_o = s2_valid_q;
   assign bus.out_last_o  = s2_valid_q && s2_last_q;
   assign bus.ovf_o       = s2_valid_q && s2_ovf_q;
   assign bus.frame_ovf_o = s2_valid_q && s2_last_q && s2_fovf_q;
   assign bus.busy_o      = s1_valid_q || s2_valid_q;
endmodule

// File: tb/tb_complex_matrix_addsub_stream.sv
// Random and directed stimulus against an integer reference model,
// driving saturating and wrapping instances in lockstep.
module tb_complex_matrix_addsub_stream;
   localparam int LANES = 4;
   localparam int WIDTH = 16;
   localparam int BEATS = 4;
   localparam int LW    = LANES * 2 * WIDTH;
   localparam int CW2   = 2 * WIDTH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          flush = 1'b0;
   logic          out_ready = 1'b1;
   logic [LW-1:0] a = '0;
   logic [LW-1:0] b = '0;
   logic [1:0]    op = 2'b00;

   always #5 clk = ~clk;

   complex_matrix_addsub_stream_if #(.LANES(LANES), .WIDTH(WIDTH)) bus_s ();
   complex_matrix_addsub_stream_if #(.LANES(LANES), .WIDTH(WIDTH)) bus_w ();

   assign bus_s.in_valid_i  = in_valid;
   assign bus_s.a_i         = a;
   assign bus_s.b_i         = b;
   assign bus_s.op_i        = op;
   assign bus_s.flush_i     = flush;
   assign bus_s.out_ready_i = out_ready;
   assign bus_w.in_valid_i  = in_valid;
   assign bus_w.a_i         = a;
   assign bus_w.b_i         = b;
   assign bus_w.op_i        = op;
   assign bus_w.flush_i     = flush;
   assign bus_w.out_ready_i = out_ready;

   complex_matrix_addsub_stream #(
      .LANES(LANES), .WIDTH(WIDTH), .BEATS(BEATS), .SATURATE(1)
   ) dut_s (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus_s)
   );

   complex_matrix_addsub_stream #(
      .LANES(LANES), .WIDTH(WIDTH), .BEATS(BEATS), .SATURATE(0)
   ) dut_w (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus_w)
   );

   typedef struct {
      logic [LW-1:0] rs;
      logic [LW-1:0] rw;
      logic          ovf;
      logic          last;
      logic          fovf;
   } exp_t;

   exp_t          q[$];
   int            fpos = 0;
   logic [1:0]    fop = 2'b00;
   logic          facc = 1'b0;
   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            out_cnt = 0;
   int            acc_cnt = 0;
   int            acc_cyc = 0;
   int            out_cyc = 0;
   logic          stalled = 1'b0;
   logic [LW-1:0] held = '0;
   logic          held_last = 1'b0;
   logic [LW-1:0] last_rs = '0;
   logic [LW-1:0] last_rw = '0;
   logic          last_ovf_s = 1'b0;
   logic          last_ovf_w = 1'b0;
   logic          last_last = 1'b0;
   logic          last_fovf = 1'b0;

   task automatic check(input string tag, input logic [LW-1:0] got,
                        input logic [LW-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [CW2-1:0] cpx(input int re, input int im);
      return {im[WIDTH-1:0], re[WIDTH-1:0]};
   endfunction

   function automatic logic [LW-1:0] rnd_data();
      logic [LW-1:0] d;
      int v;
      d = '0;
      for (int k = 0; k < 2 * LANES; k++) begin
         if ($urandom_range(1, 0) == 1) v = int'($urandom);
         else v = int'($urandom_range(2000, 0)) - 1000;
         d[k*WIDTH +: WIDTH] = v[WIDTH-1:0];
      end
      return d;
   endfunction

   task automatic model_clear();
      q.delete();
      fpos = 0;
      facc = 1'b0;
   endtask

   // Plain integer arithmetic, then clamp or truncate.
   task automatic model_push(input logic [LW-1:0] av, input logic [LW-1:0] bv,
                             input logic [1:0] o);
      exp_t e;
      int x, y, s, mx, mn;
      logic sub, ov;
      mx = (1 <<< (WIDTH - 1)) - 1;
      mn = -(1 <<< (WIDTH - 1));
      if (fpos == 0) fop = (o == 2'b11) ? 2'b00 : o;
      e.rs  = '0;
      e.rw  = '0;
      e.ovf = 1'b0;
      for (int k = 0; k < 2 * LANES; k++) begin
         x   = int'($signed(av[k*WIDTH +: WIDTH]));
         y   = int'($signed(bv[k*WIDTH +: WIDTH]));
         sub = (fop == 2'b01) || (fop == 2'b10 && (k % 2) == 1);
         s   = sub ? x - y : x + y;
         ov  = (s > mx) || (s < mn);
         e.ovf = e.ovf | ov;
         e.rw[k*WIDTH +: WIDTH] = s[WIDTH-1:0];
         if (s > mx) e.rs[k*WIDTH +: WIDTH] = mx[WIDTH-1:0];
         else if (s < mn) e.rs[k*WIDTH +: WIDTH] = mn[WIDTH-1:0];
         else e.rs[k*WIDTH +: WIDTH] = s[WIDTH-1:0];
      end
      facc   = facc | e.ovf;
      e.last = (fpos == BEATS - 1);
      e.fovf = e.last & facc;
      if (e.last) facc = 1'b0;
      fpos = (fpos + 1) % BEATS;
      q.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      cyc++;
      if (rst) begin
         model_clear();
         stalled = 1'b0;
         return;
      end
      check("busy", LW'(bus_s.busy_o), LW'(q.size() != 0));
      check("in_ready", LW'(bus_s.in_ready_o),
            LW'(!flush && (q.size() < 2 || out_ready)));
      if (bus_s.out_valid_o) begin
         if (stalled) begin
            check("hold_res", bus_s.result_o, held);
            check("hold_last", LW'(bus_s.out_last_o), LW'(held_last));
         end
         if (q.size() == 0) begin
            check("spurious_out", LW'(bus_s.out_valid_o), LW'(0));
         end else if (out_ready) begin
            e = q.pop_front();
            check("res_sat", bus_s.result_o, e.rs);
            check("res_wrap", bus_w.result_o, e.rw);
            check("valid_wrap", LW'(bus_w.out_valid_o), LW'(1));
            check("ovf_sat", LW'(bus_s.ovf_o), LW'(e.ovf));
            check("ovf_wrap", LW'(bus_w.ovf_o), LW'(e.ovf));
            check("last", LW'(bus_s.out_last_o), LW'(e.last));
            check("frame_ovf", LW'(bus_s.frame_ovf_o), LW'(e.fovf));
            last_rs    = bus_s.result_o;
            last_rw    = bus_w.result_o;
            last_ovf_s = bus_s.ovf_o;
            last_ovf_w = bus_w.ovf_o;
            last_last  = bus_s.out_last_o;
            last_fovf  = bus_s.frame_ovf_o;
            out_cyc    = cyc;
            out_cnt++;
            stalled = 1'b0;
         end else begin
            stalled   = 1'b1;
            held      = bus_s.result_o;
            held_last = bus_s.out_last_o;
         end
      end else begin
         if (stalled) check("dropped_beat", LW'(bus_s.out_valid_o), LW'(1));
         stalled = 1'b0;
      end
      if (flush) begin
         model_clear();
         stalled = 1'b0;
      end else if (in_valid && bus_s.in_ready_o) begin
         model_push(a, b, op);
         acc_cnt++;
         acc_cyc = cyc;
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [LW-1:0] av, input logic [LW-1:0] bv,
                       input logic [1:0] o);
      int start;
      start = acc_cnt;
      a = av;
      b = bv;
      op = o;
      in_valid = 1'b1;
      for (int n = 0; n < 50 && acc_cnt == start; n++) step();
      in_valid = 1'b0;
      check("send_timeout", LW'(acc_cnt != start), LW'(1));
   endtask

   task automatic wait_out(input int n);
      for (int i = 0; i < 30 && out_cnt < n; i++) step();
      check("out_timeout", LW'(out_cnt >= n), LW'(1));
   endtask

   initial begin
      logic [LW-1:0] av, bv;
      int oc, start;

      repeat (3) step();
      check("rst_valid", LW'(bus_s.out_valid_o), LW'(0));
      check("rst_busy", LW'(bus_s.busy_o), LW'(0));
      check("rst_last", LW'(bus_s.out_last_o), LW'(0));
      check("rst_ovf", LW'(bus_s.ovf_o), LW'(0));
      check("rst_fovf", LW'(bus_s.frame_ovf_o), LW'(0));
      check("rst_result", bus_s.result_o, LW'(0));
      rst = 1'b0;
      #1;
      check("rdy_after_rst", LW'(bus_s.in_ready_o), LW'(1));

      av = '0;
      bv = '0;
      av[CW2-1:0] = cpx(100, -50);
      bv[CW2-1:0] = cpx(20, 30);
      oc = out_cnt;
      send(av, bv, 2'b00);
      wait_out(oc + 1);
      check("add_latency", LW'(out_cyc - acc_cyc), LW'(2));
      check("add_res", LW'(last_rs[CW2-1:0]), LW'(cpx(120, -20)));
      check("add_ovf", LW'(last_ovf_s), LW'(0));
      repeat (3) send('0, '0, 2'b01);
      wait_out(oc + 4);

      av = '0;
      bv = '0;
      av[CW2-1:0] = cpx(-32768, 0);
      bv[CW2-1:0] = cpx(1, 0);
      send(av, bv, 2'b01);
      wait_out(oc + 5);
      check("sat_res", LW'(last_rs[CW2-1:0]), LW'(cpx(-32768, 0)));
      check("sat_ovf", LW'(last_ovf_s), LW'(1));
      check("wrap_res", LW'(last_rw[CW2-1:0]), LW'(cpx(32767, 0)));
      check("wrap_ovf", LW'(last_ovf_w), LW'(1));
      repeat (3) send('0, '0, 2'b00);
      wait_out(oc + 8);
      check("sat_frame_last", LW'(last_last), LW'(1));
      check("sat_frame_ovf", LW'(last_fovf), LW'(1));

      av = '0;
      bv = '0;
      av[CW2-1:0] = cpx(5, 7);
      bv[CW2-1:0] = cpx(3, 4);
      for (int i = 0; i < 4; i++) begin
         send(av, bv, (i < 2) ? 2'b10 : 2'b01);
         wait_out(oc + 9 + i);
         check($sformatf("conj_beat%0d", i), LW'(last_rs[CW2-1:0]),
               LW'(cpx(8, 3)));
      end

      oc = out_cnt;
      start = acc_cnt;
      out_ready = 1'b0;
      a = rnd_data();
      b = rnd_data();
      op = 2'($urandom);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         int prev;
         prev = acc_cnt;
         step();
         if (acc_cnt != prev) begin
            a = rnd_data();
            b = rnd_data();
         end
      end
      check("bp_accepts", LW'(acc_cnt - start), LW'(2));
      check("bp_ready_low", LW'(bus_s.in_ready_o), LW'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 20 && acc_cnt - start < 4; i++) begin
         int prev;
         prev = acc_cnt;
         step();
         if (acc_cnt != prev) begin
            a = rnd_data();
            b = rnd_data();
         end
      end
      in_valid = 1'b0;
      wait_out(oc + 4);
      check("bp_last", LW'(last_last), LW'(1));

      send(rnd_data(), rnd_data(), 2'b00);
      send(rnd_data(), rnd_data(), 2'b00);
      flush = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      check("flush_ready", LW'(bus_s.in_ready_o), LW'(0));
      monitor();
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", LW'(bus_s.out_valid_o), LW'(0));
      check("flush_busy", LW'(bus_s.busy_o), LW'(0));
      oc = out_cnt;
      send(rnd_data(), rnd_data(), 2'b10);
      for (int i = 0; i < 3; i++) send(rnd_data(), rnd_data(), 2'b00);
      wait_out(oc + 4);
      check("flush_last", LW'(last_last), LW'(1));

      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(3, 0) != 0);
         out_ready = ($urandom_range(2, 0) != 0);
         flush     = ($urandom_range(39, 0) == 0);
         op        = 2'($urandom);
         a         = rnd_data();
         b         = rnd_data();
         step();
      end
      flush = 1'b0;

      out_ready = 1'b0;
      in_valid = 1'b1;
      repeat (3) step();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", LW'(bus_s.out_valid_o), LW'(0));
      check("arst_busy", LW'(bus_s.busy_o), LW'(0));
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      #1;
      check("arst_ready", LW'(bus_s.in_ready_o), LW'(1));
      oc = out_cnt;
      for (int i = 0; i < 4; i++) send(rnd_data(), rnd_data(), 2'b01);
      wait_out(oc + 4);
      check("arst_last", LW'(last_last), LW'(1));

      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (6) step();
      check("drain_empty", LW'(q.size()), LW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/complex_matrix_addsub_stream.md
COMPLEX_MATRIX_ADDSUB_STREAM -- requirements
Module: complex_matrix_addsub_stream

Interface
REQ-001 Parameter LANES, default 4, number of complex elements processed per beat.
REQ-002 Parameter WIDTH, default 16, signed two's-complement width of each real and imaginary part.
REQ-003 Parameter BEATS, default 4, beats per matrix frame (matrix element count = LANES*BEATS); BEATS >= 1.
REQ-004 Parameter SATURATE, default 1: 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-005 clk_i  input  1  single clock; all state on rising edge.
REQ-006 rst_i  input  1  reset, asynchronous assert, active-high.
REQ-007 in_valid_i  input  1  input beat valid.
REQ-008 in_ready_o  output  1  input beat accepted when in_valid_i and in_ready_o are both high.
REQ-009 a_i  input  LANES*2*WIDTH  operand A; lane k = {imag, real} at bits [2*WIDTH*k +: 2*WIDTH], real in the low half.
REQ-010 b_i  input  LANES*2*WIDTH  operand B, same packing as a_i.
REQ-011 op_i  input  2  00 = A+B, 01 = A-B, 10 = A+conj(B), 11 = treated as 00.
REQ-012 flush_i  input  1  synchronous discard of all in-flight data and frame state.
REQ-013 result_o  output  LANES*2*WIDTH  result beat, same packing as a_i.
REQ-014 out_valid_o  output  1  result beat valid.
REQ-015 out_ready_i  input  1  result beat consumed when out_valid_o and out_ready_i are both high.
REQ-016 out_last_o  output  1  high on the final beat of a frame (beat index BEATS-1).
REQ-017 ovf_o  output  1  any lane/part of the current output beat overflowed.
REQ-018 frame_ovf_o  output  1  on the last beat: OR of ovf over the whole frame; 0 on other beats.
REQ-019 busy_o  output  1  high while any pipeline stage holds valid data.

Function
REQ-020 Pipeline: stage 1 registers (WIDTH+1)-bit sums per part; stage 2 registers the saturated or wrapped WIDTH-bit result plus flags.
REQ-021 Latency is 2 cycles from input handshake to out_valid_o with out_ready_i held high; throughput is one beat per cycle.
REQ-022 Each stage loads when it is empty or its contents move on in the same cycle; in_ready_o = stage 1 empty or stage 1 advancing (combinational path from out_ready_i permitted).
REQ-023 Held data (stalled stage) and result_o stay stable while out_valid_o is high and out_ready_i is low; no beat is dropped or duplicated.
REQ-024 Input beat counter counts 0..BEATS-1 on accepted beats and wraps to 0; op_i is latched at beat index 0 and applies to the whole frame; op_i changes mid-frame are ignored.
REQ-025 The beat index and last flag travel with the data; out_last_o is high only for beat index BEATS-1; with BEATS=1 every beat is last.
REQ-026 Arithmetic: real = ar +/- br; imag = ai +/- bi for add/sub; for conj-add imag = ai - bi, real = ar + br; computed at WIDTH+1 bits.
REQ-027 Overflow of a part means the WIDTH+1-bit result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. On overflow, SATURATE=1 clamps to the nearest bound; SATURATE=0 keeps the low WIDTH bits. ovf_o is set in both modes.
REQ-028 The frame overflow accumulator ORs ovf per output beat and is cleared after the last beat is handed to stage 2.
REQ-029 flush_i high clears all stage valids, the beat counter and the frame overflow accumulator at the next edge. It has priority over any simultaneous handshake, and the input beat offered that cycle is not accepted (in_ready_o low while flush_i is high).
REQ-030 After a flush, the next accepted beat is index 0 and op_i is re-latched.

Reset
REQ-031 While rst_i is high: out_valid_o=0, busy_o=0, out_last_o=0, ovf_o=0, frame_ovf_o=0, result_o=0, beat counter=0, latched op=00.
REQ-032 in_ready_o is 1 from the first cycle after rst_i deasserts; reset asserted mid-frame discards all in-flight beats.

Verification
REQ-033 Reset: assert rst_i asynchronously mid-stream -> out_valid_o=0 and busy_o=0 immediately; in_ready_o=1 after release.
REQ-034 Add (WIDTH=16): a=(re 100, im -50), b=(20, 30), op 00 -> result (120, -20) exactly 2 cycles later; ovf_o=0.
REQ-035 Saturation: op 01, a=(-32768, 0), b=(1, 0) -> (-32768, 0), ovf_o=1; same stimulus with SATURATE=0 -> (32767, 0), ovf_o=1.
REQ-036 Conj-add: a=(5, 7), b=(3, 4), op 10 -> (8, 3); op_i switched to 01 on beat 2 -> beats 2-3 still use conj-add.
REQ-037 Backpressure: 4-beat frame, out_ready_i low for 4 cycles -> in_ready_o drops once both stages are full; all 4 beats emerge in order unchanged; out_last_o only on beat 3; frame_ovf_o reflects the OR over the frame.
REQ-038 Flush: flush_i pulse after beat 1 is accepted -> next cycle out_valid_o=0 and busy_o=0; the next accepted beat is index 0 and out_last_o appears 4 beats later.
